// File: rtl/player_controller.sv
// ---------------------------------------------------------------------------
// player_controller
//   Movement and score engine for one Crossy Robbers player. Keyboard
//   keycodes become tile-aligned hop animations paced by VGA frames, with
//   edge-of-field clamping, scoring on the top row and a frozen respawn
//   period after a hit or a score.
//
// Ports:
//   Clk         in   1  system clock (50 MHz)
//   Reset       in   1  asynchronous, active-high reset
//   frame_vs    in   1  raw VGA_VS (active low), asynchronous to Clk
//   keycode     in   8  current USB HID keycode, 0x00 = none
//   hit         in   1  level-sensitive collision flag from hazard logic
//   PlayerX     out 10  sprite top-left X in pixels
//   PlayerY     out 10  sprite top-left Y in pixels
//   PlayerScore out  8  binary score, saturating at SCORE_MAX
//   Facing      out  2  0 = up, 1 = down, 2 = left, 3 = right
//   Hopping     out  1  high while a hop is in progress
//   Respawning  out  1  high while frozen after a hit or a score
//
// Optional feature macro: PLAYER_HOLD_REPEAT_EN
//   When defined, a key held in IDLE chains hops back-to-back; leaving
//   RESPAWN still needs a fresh press. When undefined only key presses
//   (0 -> 1 transitions of a valid direction) start hops.
// ---------------------------------------------------------------------------
module player_controller #(
  parameter int IS_PLAYER_ONE  = 1,
  parameter int START_X        = 192,
  parameter int START_Y        = 448,
  parameter int TILE           = 32,
  parameter int HOP_FRAMES     = 8,
  parameter int RESPAWN_FRAMES = 30,
  parameter int SCORE_MAX      = 99
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_vs,
  input  logic [7:0] keycode,
  input  logic       hit,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic [7:0] PlayerScore,
  output logic [1:0] Facing,
  output logic       Hopping,
  output logic       Respawning
);

  localparam logic [9:0] START_X_C   = 10'(START_X);
  localparam logic [9:0] START_Y_C   = 10'(START_Y);
  localparam logic [9:0] TILE_C      = 10'(TILE);
  localparam logic [9:0] STEP_C      = 10'(TILE / HOP_FRAMES);
  // Highest coordinate from which a right/down hop still lands on the field.
  localparam logic [9:0] X_LAST_C    = 10'(640 - 2 * TILE);
  localparam logic [9:0] Y_LAST_C    = 10'(480 - 2 * TILE);
  localparam int         HCW         = (HOP_FRAMES > 1) ? $clog2(HOP_FRAMES) : 1;
  localparam int         RCW         = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [HCW-1:0] HOP_LAST_C  = HCW'(HOP_FRAMES - 1);
  localparam logic [RCW-1:0] RESP_LAST_C = RCW'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] SCORE_MAX_C = 8'(SCORE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOP     = 2'd1,
    RESPAWN = 2'd2
  } state_t;

  state_t         state_q;
  logic [9:0]     x_q, y_q, tgt_x_q, tgt_y_q;
  logic [9:0]     tgt_x_d, tgt_y_d;
  logic [7:0]     score_q;
  logic [1:0]     facing_q;
  logic           hopping_q, respawning_q, prev_valid_q;
  logic [HCW-1:0] hop_cnt_q;
  logic [RCW-1:0] resp_cnt_q;
  logic           vs_meta_q, vs_sync_q, vs_prev_q;

  logic           tick, dir_valid, in_bounds, start;
  logic [1:0]     dir;
  logic           hop_last, resp_last, score_land, go_respawn;

  // VS synchroniser and edge history; all clear to 1 so reset makes no edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      vs_meta_q <= frame_vs;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  assign tick = vs_prev_q & ~vs_sync_q;

  // Keycode to direction decode for this player's key set.
  always_comb begin
    dir_valid = 1'b0;
    dir       = 2'd0;
    if (IS_PLAYER_ONE != 0) begin
      case (keycode)
        8'h1A:   begin dir_valid = 1'b1; dir = 2'd0; end
        8'h16:   begin dir_valid = 1'b1; dir = 2'd1; end
        8'h04:   begin dir_valid = 1'b1; dir = 2'd2; end
        8'h07:   begin dir_valid = 1'b1; dir = 2'd3; end
        default: begin dir_valid = 1'b0; dir = 2'd0; end
      endcase
    end else begin
      case (keycode)
        8'h52:   begin dir_valid = 1'b1; dir = 2'd0; end
        8'h51:   begin dir_valid = 1'b1; dir = 2'd1; end
        8'h50:   begin dir_valid = 1'b1; dir = 2'd2; end
        8'h4F:   begin dir_valid = 1'b1; dir = 2'd3; end
        default: begin dir_valid = 1'b0; dir = 2'd0; end
      endcase
    end
  end

  // Target tile for the decoded direction and whether it stays on the field.
  always_comb begin
    tgt_x_d   = x_q;
    tgt_y_d   = y_q;
    in_bounds = 1'b0;
    case (dir)
      2'd0:    begin in_bounds = (y_q >= TILE_C);   tgt_y_d = y_q - TILE_C; end
      2'd1:    begin in_bounds = (y_q <= Y_LAST_C); tgt_y_d = y_q + TILE_C; end
      2'd2:    begin in_bounds = (x_q >= TILE_C);   tgt_x_d = x_q - TILE_C; end
      default: begin in_bounds = (x_q <= X_LAST_C); tgt_x_d = x_q + TILE_C; end
    endcase
  end

`ifdef PLAYER_HOLD_REPEAT_EN
  logic need_fresh_q;

  // After respawn a held key must be released before it can hop again.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      need_fresh_q <= 1'b0;
    end else if (tick) begin
      if (state_q == RESPAWN && resp_last) begin
        need_fresh_q <= 1'b1;
      end else if (!dir_valid) begin
        need_fresh_q <= 1'b0;
      end else begin
        need_fresh_q <= need_fresh_q;
      end
    end else begin
      need_fresh_q <= need_fresh_q;
    end
  end

  assign start = dir_valid & (~prev_valid_q | ~need_fresh_q);
`else
  assign start = dir_valid & ~prev_valid_q;
`endif

  assign hop_last   = (hop_cnt_q == HOP_LAST_C);
  assign resp_last  = (resp_cnt_q == RESP_LAST_C);
  // hit outranks a landing, so a hit on the top-row landing tick scores nothing.
  assign score_land = (state_q == HOP) & hop_last & (tgt_y_q == 10'd0) & ~hit;
  assign go_respawn = (((state_q == IDLE) | (state_q == HOP)) & hit) | score_land;

  // Player FSM: all state advances only on frame ticks.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      x_q          <= START_X_C;
      y_q          <= START_Y_C;
      tgt_x_q      <= START_X_C;
      tgt_y_q      <= START_Y_C;
      score_q      <= 8'd0;
      facing_q     <= 2'd0;
      hopping_q    <= 1'b0;
      respawning_q <= 1'b0;
      prev_valid_q <= 1'b0;
      hop_cnt_q    <= '0;
      resp_cnt_q   <= '0;
    end else if (tick) begin
      prev_valid_q <= dir_valid;
      if (go_respawn) begin
        state_q      <= RESPAWN;
        x_q          <= START_X_C;
        y_q          <= START_Y_C;
        hopping_q    <= 1'b0;
        respawning_q <= 1'b1;
        resp_cnt_q   <= '0;
        if (score_land && (score_q != SCORE_MAX_C)) begin
          score_q <= score_q + 8'd1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              facing_q <= dir;
              if (in_bounds) begin
                state_q   <= HOP;
                hop_cnt_q <= '0;
                hopping_q <= 1'b1;
                tgt_x_q   <= tgt_x_d;
                tgt_y_q   <= tgt_y_d;
              end
            end
          end
          HOP: begin
            if (hop_last) begin
              x_q       <= tgt_x_q;
              y_q       <= tgt_y_q;
              hopping_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              hop_cnt_q <= hop_cnt_q + HCW'(1);
              case (facing_q)
                2'd0:    y_q <= y_q - STEP_C;
                2'd1:    y_q <= y_q + STEP_C;
                2'd2:    x_q <= x_q - STEP_C;
                default: x_q <= x_q + STEP_C;
              endcase
            end
          end
          RESPAWN: begin
            if (resp_last) begin
              state_q      <= IDLE;
              respawning_q <= 1'b0;
              facing_q     <= 2'd0;
            end else begin
              resp_cnt_q <= resp_cnt_q + RCW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign PlayerX     = x_q;
  assign PlayerY     = y_q;
  assign PlayerScore = score_q;
  assign Facing      = facing_q;
  assign Hopping     = hopping_q;
  assign Respawning  = respawning_q;

endmodule

// File: tb/tb_player_controller.sv
module tb_player_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_vs = 1'b1;
  logic [7:0] key_a = 8'h00, key_b = 8'h00, key_c = 8'h00;
  logic       hit_a = 1'b0, hit_b = 1'b0, hit_c = 1'b0;
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic [7:0] sc_a, sc_b, sc_c;
  logic [1:0] f_a, f_b, f_c;
  logic       h_a, h_b, h_c, r_a, r_b, r_c;

  int checks = 0;
  int errors = 0;

  always #10 Clk = ~Clk;

  // Player one with default placement.
  player_controller #(.IS_PLAYER_ONE(1)) u_p1 (
    .Clk(Clk), .Reset(Reset), .frame_vs(frame_vs), .keycode(key_a), .hit(hit_a),
    .PlayerX(x_a), .PlayerY(y_a), .PlayerScore(sc_a), .Facing(f_a),
    .Hopping(h_a), .Respawning(r_a));

  // Player two starting on the right edge.
  player_controller #(.IS_PLAYER_ONE(0), .START_X(608), .START_Y(448)) u_p2 (
    .Clk(Clk), .Reset(Reset), .frame_vs(frame_vs), .keycode(key_b), .hit(hit_b),
    .PlayerX(x_b), .PlayerY(y_b), .PlayerScore(sc_b), .Facing(f_b),
    .Hopping(h_b), .Respawning(r_b));

  // Player one starting one row below the goal, short respawn: fast scoring.
  player_controller #(.IS_PLAYER_ONE(1), .START_Y(32), .RESPAWN_FRAMES(2)) u_sat (
    .Clk(Clk), .Reset(Reset), .frame_vs(frame_vs), .keycode(key_c), .hit(hit_c),
    .PlayerX(x_c), .PlayerY(y_c), .PlayerScore(sc_c), .Facing(f_c),
    .Hopping(h_c), .Respawning(r_c));

  // One VGA frame: VS low long enough to cross the synchroniser, then high.
  task automatic do_tick;
    frame_vs = 1'b0;
    repeat (3) @(posedge Clk);
    #1 frame_vs = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({x_a, y_a} !== {10'd192, 10'd448}) begin
      errors++; $display("FAIL reset_pos got %0d,%0d exp 192,448", x_a, y_a);
    end
    checks++;
    if ({sc_a, f_a, h_a, r_a} !== 12'd0) begin
      errors++; $display("FAIL reset_flags got sc=%0d f=%0d h=%0d r=%0d exp all 0", sc_a, f_a, h_a, r_a);
    end
    checks++;
    if ({x_b, y_c} !== {10'd608, 10'd32}) begin
      errors++; $display("FAIL reset_params got x_b=%0d y_c=%0d exp 608,32", x_b, y_c);
    end
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic test_hop;
    int exp_y;
    logic exp_h;
    key_a = 8'h1A;
    for (int i = 1; i <= 10; i++) begin
      do_tick();
      exp_y = (i <= 1) ? 448 : ((i >= 9) ? 416 : 448 - 4 * (i - 1));
      exp_h = (i <= 8);
`ifdef PLAYER_HOLD_REPEAT_EN
      if (i == 10) exp_h = 1'b1;
`endif
      checks++;
      if (y_a !== 10'(exp_y) || h_a !== exp_h) begin
        errors++; $display("FAIL hop_step tick %0d got y=%0d h=%0d exp y=%0d h=%0d", i, y_a, h_a, exp_y, exp_h);
      end
    end
    checks++;
    if (x_a !== 10'd192 || f_a !== 2'd0) begin
      errors++; $display("FAIL hop_x got x=%0d f=%0d exp 192,0", x_a, f_a);
    end
    key_a = 8'h00;
`ifdef PLAYER_HOLD_REPEAT_EN
    repeat (8) do_tick();
    checks++;
    if (y_a !== 10'd384 || h_a !== 1'b0) begin
      errors++; $display("FAIL hop_chain2 got y=%0d h=%0d exp 384,0", y_a, h_a);
    end
`endif
    do_tick();
  endtask

`ifdef PLAYER_HOLD_REPEAT_EN
  task automatic test_hold_repeat;
    key_a = 8'h16;
    for (int i = 1; i <= 20; i++) begin
      do_tick();
      if (i == 9) begin
        checks++;
        if (y_a !== 10'd416 || h_a !== 1'b0) begin
          errors++; $display("FAIL repeat_land1 got y=%0d h=%0d exp 416,0", y_a, h_a);
        end
      end
      if (i == 10) begin
        checks++;
        if (y_a !== 10'd416 || h_a !== 1'b1) begin
          errors++; $display("FAIL repeat_start2 got y=%0d h=%0d exp 416,1", y_a, h_a);
        end
      end
      if (i >= 18) begin
        checks++;
        if (y_a !== 10'd448 || h_a !== 1'b0 || f_a !== 2'd1) begin
          errors++; $display("FAIL repeat_clamp tick %0d got y=%0d h=%0d f=%0d exp 448,0,1", i, y_a, h_a, f_a);
        end
      end
    end
    key_a = 8'h00;
    do_tick();
  endtask
`endif

  task automatic test_clamp;
    key_b = 8'h4F;
    do_tick();
    checks++;
    if (f_b !== 2'd3 || h_b !== 1'b0 || x_b !== 10'd608) begin
      errors++; $display("FAIL clamp_right got f=%0d h=%0d x=%0d exp 3,0,608", f_b, h_b, x_b);
    end
    key_b = 8'h00;
    do_tick();
    key_b = 8'h50;
    do_tick();
    checks++;
    if (f_b !== 2'd2 || h_b !== 1'b1 || x_b !== 10'd608) begin
      errors++; $display("FAIL left_start got f=%0d h=%0d x=%0d exp 2,1,608", f_b, h_b, x_b);
    end
    key_b = 8'h00;
    repeat (8) do_tick();
    checks++;
    if (x_b !== 10'd576 || h_b !== 1'b0 || y_b !== 10'd448) begin
      errors++; $display("FAIL left_land got x=%0d h=%0d y=%0d exp 576,0,448", x_b, h_b, y_b);
    end
  endtask

  task automatic test_score;
    int n;
`ifdef PLAYER_HOLD_REPEAT_EN
    n = 13;
`else
    n = 12;
`endif
    for (int k = 0; k < n; k++) begin
      key_a = 8'h1A; do_tick();
      key_a = 8'h00; repeat (8) do_tick();
    end
    checks++;
    if (y_a !== 10'd32) begin
      errors++; $display("FAIL climb got y=%0d exp 32", y_a);
    end
    key_a = 8'h1A; do_tick();
    key_a = 8'h00; repeat (7) do_tick();
    checks++;
    if (y_a !== 10'd4 || h_a !== 1'b1) begin
      errors++; $display("FAIL top_approach got y=%0d h=%0d exp 4,1", y_a, h_a);
    end
    do_tick();
    checks++;
    if (sc_a !== 8'd1 || r_a !== 1'b1 || h_a !== 1'b0 || {x_a, y_a} !== {10'd192, 10'd448}) begin
      errors++; $display("FAIL score_land got sc=%0d r=%0d h=%0d pos=%0d,%0d exp 1,1,0,192,448", sc_a, r_a, h_a, x_a, y_a);
    end
    for (int i = 1; i <= 29; i++) begin
      do_tick();
      checks++;
      if (r_a !== 1'b1) begin
        errors++; $display("FAIL score_frozen tick %0d got r=%0d exp 1", i, r_a);
      end
    end
    do_tick();
    checks++;
    if (r_a !== 1'b0 || sc_a !== 8'd1) begin
      errors++; $display("FAIL score_exit got r=%0d sc=%0d exp 0,1", r_a, sc_a);
    end
  endtask

  task automatic test_hit;
    key_a = 8'h04; do_tick();
    checks++;
    if (f_a !== 2'd2 || h_a !== 1'b1) begin
      errors++; $display("FAIL hit_hopstart got f=%0d h=%0d exp 2,1", f_a, h_a);
    end
    key_a = 8'h00; repeat (3) do_tick();
    checks++;
    if (x_a !== 10'd180) begin
      errors++; $display("FAIL hit_midhop got x=%0d exp 180", x_a);
    end
    hit_a = 1'b1; do_tick(); hit_a = 1'b0;
    checks++;
    if (r_a !== 1'b1 || h_a !== 1'b0 || sc_a !== 8'd1 || {x_a, y_a} !== {10'd192, 10'd448}) begin
      errors++; $display("FAIL hit_respawn got r=%0d h=%0d sc=%0d pos=%0d,%0d exp 1,0,1,192,448", r_a, h_a, sc_a, x_a, y_a);
    end
    // Presses during respawn are ignored; the key stays held into the exit.
    for (int i = 0; i < 29; i++) begin
      key_a = ((i % 2) == 0 || i >= 26) ? 8'h1A : 8'h00;
      if (i == 10) hit_a = 1'b1;
      do_tick();
      hit_a = 1'b0;
      checks++;
      if (r_a !== 1'b1 || h_a !== 1'b0 || {x_a, y_a} !== {10'd192, 10'd448}) begin
        errors++; $display("FAIL hit_frozen tick %0d got r=%0d h=%0d pos=%0d,%0d exp 1,0,192,448", i, r_a, h_a, x_a, y_a);
      end
    end
    do_tick();
    checks++;
    if (r_a !== 1'b0 || f_a !== 2'd0) begin
      errors++; $display("FAIL hit_exit got r=%0d f=%0d exp 0,0", r_a, f_a);
    end
    do_tick();
    checks++;
    if (h_a !== 1'b0 || y_a !== 10'd448) begin
      errors++; $display("FAIL held_no_hop got h=%0d y=%0d exp 0,448", h_a, y_a);
    end
    key_a = 8'h00; do_tick();
    key_a = 8'h1A; do_tick();
    key_a = 8'h00; repeat (8) do_tick();
    checks++;
    if (y_a !== 10'd416 || sc_a !== 8'd1) begin
      errors++; $display("FAIL post_hit_hop got y=%0d sc=%0d exp 416,1", y_a, sc_a);
    end
  endtask

  task automatic test_hit_landing;
    key_c = 8'h1A; do_tick();
    key_c = 8'h00; repeat (7) do_tick();
    hit_c = 1'b1; do_tick(); hit_c = 1'b0;
    checks++;
    if (sc_c !== 8'd0 || r_c !== 1'b1 || y_c !== 10'd32) begin
      errors++; $display("FAIL hit_on_landing got sc=%0d r=%0d y=%0d exp 0,1,32", sc_c, r_c, y_c);
    end
    repeat (2) do_tick();
    checks++;
    if (r_c !== 1'b0) begin
      errors++; $display("FAIL short_respawn got r=%0d exp 0", r_c);
    end
  endtask

  task automatic test_saturate;
    for (int k = 1; k <= 100; k++) begin
      key_c = 8'h1A; do_tick();
      key_c = 8'h00; repeat (8) do_tick();
      if (k == 1 || k == 99 || k == 100) begin
        checks++;
        if (sc_c !== 8'((k > 99) ? 99 : k) || r_c !== 1'b1) begin
          errors++; $display("FAIL saturate round %0d got sc=%0d r=%0d exp %0d,1", k, sc_c, r_c, (k > 99) ? 99 : k);
        end
      end
      repeat (2) do_tick();
    end
  endtask

  task automatic test_reset_mid_hop;
    key_a = 8'h1A; do_tick();
    key_a = 8'h00; repeat (3) do_tick();
    checks++;
    if (y_a !== 10'd404 || h_a !== 1'b1) begin
      errors++; $display("FAIL prereset_hop got y=%0d h=%0d exp 404,1", y_a, h_a);
    end
    #3 Reset = 1'b1;
    #1;
    checks++;
    if ({x_a, y_a} !== {10'd192, 10'd448} || {sc_a, f_a, h_a, r_a} !== 12'd0) begin
      errors++; $display("FAIL async_reset got pos=%0d,%0d sc=%0d f=%0d h=%0d r=%0d exp 192,448,0,0,0,0", x_a, y_a, sc_a, f_a, h_a, r_a);
    end
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hop();
`ifdef PLAYER_HOLD_REPEAT_EN
    test_hold_repeat();
`endif
    test_clamp();
    test_score();
    test_hit();
    test_hit_landing();
    test_saturate();
    test_reset_mid_hop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
